// File: rtl/sm83_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sm83_alu_pkg
// Purpose  : Opcode and FSM encodings, flag indices and opcode-class helpers
//            shared by the sequential SM83 ALU.
// Revision : 1.0 - initial release
// ============================================================================
package sm83_alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,  OP_ADC  = 5'd1,  OP_SUB  = 5'd2,  OP_SBC = 5'd3,
        OP_AND  = 5'd4,  OP_XOR  = 5'd5,  OP_OR   = 5'd6,  OP_CP  = 5'd7,
        OP_RLC  = 5'd8,  OP_RRC  = 5'd9,  OP_RL   = 5'd10, OP_RR  = 5'd11,
        OP_SLA  = 5'd12, OP_SRA  = 5'd13, OP_SWAP = 5'd14, OP_SRL = 5'd15,
        OP_BIT  = 5'd16, OP_RES  = 5'd17, OP_SET  = 5'd18, OP_DAA = 5'd19,
        OP_INC  = 5'd20, OP_DEC  = 5'd21
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_H = 1;
    localparam int FLAG_C = 0;

    // Ops that run through the slice adder, one slice per EXEC cycle
    function automatic logic op_is_serial(input logic [4:0] op);
        case (op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CP, OP_INC, OP_DEC: op_is_serial = 1'b1;
            default:                                              op_is_serial = 1'b0;
        endcase
    endfunction

    function automatic logic op_is_sub(input logic [4:0] op);
        case (op)
            OP_SUB, OP_SBC, OP_CP, OP_DEC: op_is_sub = 1'b1;
            default:                       op_is_sub = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_slice.sv
`default_nettype none
// ============================================================================
// Module   : alu_slice
// Purpose  : S-bit add/subtract slice with carry-in, carry-out and the carry
//            out of bit 3. Carry/borrow are true (borrow=1 means borrow).
// Revision : 1.0 - initial release
// ============================================================================
module alu_slice #(
    parameter int S = 4
) (
    input  logic [S-1:0] i_a,
    input  logic [S-1:0] i_b,
    input  logic         i_sub,
    input  logic         i_cin,
    output logic [S-1:0] o_sum,
    output logic         o_cout,
    output logic         o_h
);

    logic [S-1:0] w_b;
    logic         w_ci;
    logic [S:0]   w_full;
    logic         w_c4;

    // Subtraction as a + ~b + ~borrow; carry outputs are inverted back to borrows
    assign w_b    = i_sub ? ~i_b : i_b;
    assign w_ci   = i_cin ^ i_sub;
    assign w_full = {1'b0, i_a} + {1'b0, w_b} + {{S{1'b0}}, w_ci};

    generate
        if (S == 4) begin : g_h_top
            assign w_c4 = w_full[4];
        end else begin : g_h_mid
            assign w_c4 = w_full[4] ^ i_a[4] ^ w_b[4];
        end
    endgenerate

    assign o_sum  = w_full[S-1:0];
    assign o_cout = w_full[S] ^ i_sub;
    assign o_h    = w_c4 ^ i_sub;

endmodule
`default_nettype wire

// File: rtl/sm83_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : sm83_alu_seq
// Purpose  : Multi-cycle SM83 ALU; add/sub family runs serially in S-bit
//            slices, everything else completes in a single EXEC cycle.
// Revision : 1.0 - initial release
// ============================================================================
module sm83_alu_seq
    import sm83_alu_pkg::*;
#(
    parameter int W = 8,
    parameter int S = 4
) (
    input  logic                 CLK,
    input  logic                 nRESET,
    input  logic                 req,
    input  logic [4:0]           op,
    input  logic [$clog2(W)-1:0] bitsel,
    input  logic [W-1:0]         a,
    input  logic [W-1:0]         b,
    input  logic [3:0]           flags_in,
    output logic                 ack,
    output logic                 busy,
    output logic                 done,
    output logic [W-1:0]         res,
    output logic [3:0]           flags,
    output logic [3:0]           flags_we
);

    localparam int NS = W / S;
    localparam int CW = (NS > 1) ? $clog2(NS) : 1;
    localparam int BW = $clog2(W);

    generate
        if ((W % 4 != 0) || (W < 8) || (S % 4 != 0) || (S < 4) || (W % S != 0)) begin : g_bad_params
            $error("sm83_alu_seq: illegal W/S combination");
        end
    endgenerate

    alu_state_t     r_state, w_state_nxt;
    logic [W-1:0]   r_a, r_b, r_acc;
    logic [4:0]     r_op;
    logic [BW-1:0]  r_bitsel;
    logic [3:0]     r_fin;
    logic [CW-1:0]  r_cnt;
    logic           r_carry, r_h;

    logic [S-1:0]   w_sa, w_sb, w_sum;
    logic           w_cout, w_hc, w_hf;
    logic           w_serial, w_sub, w_last, w_cin0;
    logic [W-1:0]   w_acc_next, w_val, w_res, w_mask;
    logic           w_bit, w_z, w_n, w_hn, w_c;
    logic [3:0]     w_we, w_new, w_flags;
    logic           w_daa_n, w_daa_cc, w_daa_hc;
    logic [7:0]     w_daa_corr, w_daa;

    assign w_serial = op_is_serial(r_op);
    assign w_sub    = op_is_sub(r_op);
    assign w_last   = !w_serial || (r_cnt == CW'(NS - 1));
    assign w_cin0   = (op == OP_ADC || op == OP_SBC) ? flags_in[FLAG_C]
                                                     : (op == OP_INC || op == OP_DEC);

    assign w_sa = S'(r_a >> (r_cnt * S));
    assign w_sb = S'(r_b >> (r_cnt * S));

    alu_slice #(.S(S)) u_slice (
        .i_a    (w_sa),
        .i_b    (w_sb),
        .i_sub  (w_sub),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout),
        .o_h    (w_hc)
    );

    // New slice enters at the top; after NS cycles the LSB slice sits at bit 0
    assign w_acc_next = (r_acc >> S) | (W'(w_sum) << (W - S));
    assign w_hf       = (r_cnt == '0) ? w_hc : r_h;

    assign w_mask = W'(1) << r_bitsel;
    assign w_bit  = |(r_a & w_mask);

    // DAA correction works on the low byte only
    assign w_daa_n    = r_fin[FLAG_N];
    assign w_daa_cc   = r_fin[FLAG_C] | (~w_daa_n & (r_a[7:0] > 8'h99));
    assign w_daa_hc   = r_fin[FLAG_H] | (~w_daa_n & (r_a[3:0] > 4'h9));
    assign w_daa_corr = {1'b0, w_daa_cc, w_daa_cc, 2'b00, w_daa_hc, w_daa_hc, 1'b0};
    assign w_daa      = w_daa_n ? (r_a[7:0] - w_daa_corr) : (r_a[7:0] + w_daa_corr);

    always_comb begin
        w_val = r_a;
        w_n   = 1'b0;
        w_hn  = 1'b0;
        w_c   = 1'b0;
        w_we  = 4'b0000;
        case (r_op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CP: begin
                w_val = w_acc_next; w_n = w_sub; w_hn = w_hf; w_c = w_cout; w_we = 4'b1111;
            end
            OP_INC, OP_DEC: begin
                w_val = w_acc_next; w_n = w_sub; w_hn = w_hf; w_we = 4'b1110;
            end
            OP_AND:  begin w_val = r_a & r_b; w_hn = 1'b1; w_we = 4'b1111; end
            OP_XOR:  begin w_val = r_a ^ r_b; w_we = 4'b1111; end
            OP_OR:   begin w_val = r_a | r_b; w_we = 4'b1111; end
            OP_RLC:  begin w_val = {r_a[W-2:0], r_a[W-1]};      w_c = r_a[W-1]; w_we = 4'b1111; end
            OP_RRC:  begin w_val = {r_a[0], r_a[W-1:1]};        w_c = r_a[0];   w_we = 4'b1111; end
            OP_RL:   begin w_val = {r_a[W-2:0], r_fin[FLAG_C]}; w_c = r_a[W-1]; w_we = 4'b1111; end
            OP_RR:   begin w_val = {r_fin[FLAG_C], r_a[W-1:1]}; w_c = r_a[0];   w_we = 4'b1111; end
            OP_SLA:  begin w_val = {r_a[W-2:0], 1'b0};          w_c = r_a[W-1]; w_we = 4'b1111; end
            OP_SRA:  begin w_val = {r_a[W-1], r_a[W-1:1]};      w_c = r_a[0];   w_we = 4'b1111; end
            OP_SWAP: begin w_val = {r_a[W/2-1:0], r_a[W-1:W/2]}; w_we = 4'b1111; end
            OP_SRL:  begin w_val = {1'b0, r_a[W-1:1]};          w_c = r_a[0];   w_we = 4'b1111; end
            OP_BIT:  begin w_hn = 1'b1; w_we = 4'b1110; end
            OP_RES:  w_val = r_a & ~w_mask;
            OP_SET:  w_val = r_a | w_mask;
            OP_DAA:  begin
                w_val = (r_a & ~W'(8'hFF)) | W'(w_daa); w_c = w_daa_cc; w_we = 4'b1011;
            end
            default: ;
        endcase
    end

    // Masked-off flag bits carry the captured flags_in through unchanged
    assign w_z     = (r_op == OP_BIT) ? ~w_bit : (w_val == '0);
    assign w_res   = (r_op == OP_CP) ? r_a : w_val;
    assign w_new   = {w_z, w_n, w_hn, w_c};
    assign w_flags = (w_new & w_we) | (r_fin & ~w_we);

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ack         = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ack = 1'b1;
                if (req) w_state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                busy = 1'b1;
                if (w_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_op     <= '0;
            r_bitsel <= '0;
            r_fin    <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_h      <= 1'b0;
            res      <= '0;
            flags    <= '0;
            flags_we <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req) begin
                        r_a      <= a;
                        r_b      <= (op == OP_INC || op == OP_DEC) ? '0 : b;
                        r_op     <= op;
                        r_bitsel <= bitsel;
                        r_fin    <= flags_in;
                        r_carry  <= w_cin0;
                        r_cnt    <= '0;
                        r_acc    <= '0;
                    end
                end
                ST_EXEC: begin
                    if (w_serial) begin
                        r_acc   <= w_acc_next;
                        r_carry <= w_cout;
                        if (r_cnt == '0) r_h <= w_hc;
                        r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
                    end
                    if (w_last) begin
                        res      <= w_res;
                        flags    <= w_flags;
                        flags_we <= w_we;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sm83_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_sm83_alu_seq
// Purpose  : Directed self-checking bench: W=8/S=4 main instance plus two
//            W=16 instances (S=4 and S=16) fed the same operands.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sm83_alu_seq;
    import sm83_alu_pkg::*;

    logic        CLK = 1'b0;
    logic        nRESET = 1'b0;
    always #5 CLK = ~CLK;

    logic        req8 = 1'b0;
    logic [4:0]  op8 = '0;
    logic [2:0]  bitsel8 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [3:0]  fin8 = '0;
    logic        ack8, busy8, done8;
    logic [7:0]  res8;
    logic [3:0]  flags8, we8;

    logic        req16 = 1'b0;
    logic [4:0]  op16 = '0;
    logic [3:0]  bitsel16 = '0;
    logic [15:0] a16 = '0, b16 = '0;
    logic [3:0]  fin16 = '0;
    logic        ack_a, busy_a, done_a, ack_b, busy_b, done_b;
    logic [15:0] res_a, res_b;
    logic [3:0]  flags_a, flags_b, we_a, we_b;

    int n_checks = 0;
    int n_errors = 0;

    sm83_alu_seq #(.W(8), .S(4)) u_dut8 (
        .CLK(CLK), .nRESET(nRESET), .req(req8), .op(op8), .bitsel(bitsel8),
        .a(a8), .b(b8), .flags_in(fin8), .ack(ack8), .busy(busy8), .done(done8),
        .res(res8), .flags(flags8), .flags_we(we8)
    );

    sm83_alu_seq #(.W(16), .S(4)) u_dut16a (
        .CLK(CLK), .nRESET(nRESET), .req(req16), .op(op16), .bitsel(bitsel16),
        .a(a16), .b(b16), .flags_in(fin16), .ack(ack_a), .busy(busy_a), .done(done_a),
        .res(res_a), .flags(flags_a), .flags_we(we_a)
    );

    sm83_alu_seq #(.W(16), .S(16)) u_dut16b (
        .CLK(CLK), .nRESET(nRESET), .req(req16), .op(op16), .bitsel(bitsel16),
        .a(a16), .b(b16), .flags_in(fin16), .ack(ack_b), .busy(busy_b), .done(done_b),
        .res(res_b), .flags(flags_b), .flags_we(we_b)
    );

    // One request on the 8-bit DUT; lat is the done cycle relative to acceptance (0 = never)
    task automatic run8(input logic [4:0] o, input logic [7:0] av, input logic [7:0] bv,
                        input logic [2:0] bs, input logic [3:0] fi,
                        output logic [7:0] r, output logic [3:0] f, output logic [3:0] we,
                        output int lat);
        @(posedge CLK); #1;
        req8 = 1'b1; op8 = o; a8 = av; b8 = bv; bitsel8 = bs; fin8 = fi;
        @(posedge CLK); #1;
        req8 = 1'b0; op8 = ~o; a8 = ~av; b8 = ~bv; bitsel8 = ~bs; fin8 = ~fi;
        lat = 0; r = '0; f = '0; we = '0;
        for (int t = 1; t <= 20; t++) begin
            if (done8) begin lat = t; r = res8; f = flags8; we = we8; break; end
            @(posedge CLK); #1;
        end
    endtask

    task automatic run16(input logic [4:0] o, input logic [15:0] av, input logic [15:0] bv,
                         output logic [15:0] ra, output logic [15:0] rb,
                         output logic [3:0] fa, output logic [3:0] fb,
                         output int la, output int lb);
        @(posedge CLK); #1;
        req16 = 1'b1; op16 = o; a16 = av; b16 = bv;
        @(posedge CLK); #1;
        req16 = 1'b0; op16 = ~o; a16 = ~av; b16 = ~bv;
        la = 0; lb = 0; ra = '0; rb = '0; fa = '0; fb = '0;
        for (int t = 1; t <= 10; t++) begin
            if (done_a && la == 0) begin la = t; ra = res_a; fa = flags_a; end
            if (done_b && lb == 0) begin lb = t; rb = res_b; fb = flags_b; end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_reset();
        n_checks++; if (res8 !== 8'h00)  begin n_errors++; $display("FAIL reset_res got=%h exp=00", res8); end
        n_checks++; if (flags8 !== 4'b0) begin n_errors++; $display("FAIL reset_flags got=%b exp=0000", flags8); end
        n_checks++; if (we8 !== 4'b0)    begin n_errors++; $display("FAIL reset_we got=%b exp=0000", we8); end
        n_checks++; if ({ack8, busy8, done8} !== 3'b100) begin n_errors++; $display("FAIL reset_hs got=%b exp=100", {ack8, busy8, done8}); end
    endtask

    task automatic test_arith();
        logic [7:0] r; logic [3:0] f, we; int lat;
        run8(OP_ADD, 8'h3A, 8'hC6, 3'd0, 4'b0000, r, f, we, lat);
        n_checks++; if (r !== 8'h00)     begin n_errors++; $display("FAIL add_res got=%h exp=00", r); end
        n_checks++; if (f !== 4'b1011)   begin n_errors++; $display("FAIL add_flags got=%b exp=1011", f); end
        n_checks++; if (we !== 4'b1111)  begin n_errors++; $display("FAIL add_we got=%b exp=1111", we); end
        n_checks++; if (lat !== 3)       begin n_errors++; $display("FAIL add_lat got=%0d exp=3", lat); end
        run8(OP_SUB, 8'h10, 8'h01, 3'd0, 4'b0000, r, f, we, lat);
        n_checks++; if ({r, f} !== {8'h0F, 4'b0110}) begin n_errors++; $display("FAIL sub got=%h/%b exp=0f/0110", r, f); end
        run8(OP_CP, 8'h10, 8'h01, 3'd0, 4'b0000, r, f, we, lat);
        n_checks++; if ({r, f} !== {8'h10, 4'b0110}) begin n_errors++; $display("FAIL cp got=%h/%b exp=10/0110", r, f); end
        run8(OP_ADC, 8'h0F, 8'h00, 3'd0, 4'b0001, r, f, we, lat);
        n_checks++; if ({r, f} !== {8'h10, 4'b0010}) begin n_errors++; $display("FAIL adc got=%h/%b exp=10/0010", r, f); end
        run8(OP_SBC, 8'h00, 8'h00, 3'd0, 4'b0001, r, f, we, lat);
        n_checks++; if ({r, f} !== {8'hFF, 4'b0111}) begin n_errors++; $display("FAIL sbc got=%h/%b exp=ff/0111", r, f); end
        run8(OP_INC, 8'hFF, 8'h55, 3'd0, 4'b0001, r, f, we, lat);
        n_checks++; if ({r, f & 4'b1110, we} !== {8'h00, 4'b1010, 4'b1110}) begin n_errors++; $display("FAIL inc got=%h/%b/%b exp=00/1010/1110", r, f & 4'b1110, we); end
        n_checks++; if (lat !== 3)       begin n_errors++; $display("FAIL inc_lat got=%0d exp=3", lat); end
        run8(OP_DEC, 8'h10, 8'h55, 3'd0, 4'b0000, r, f, we, lat);
        n_checks++; if ({r, f & 4'b1110, we} !== {8'h0F, 4'b0110, 4'b1110}) begin n_errors++; $display("FAIL dec got=%h/%b/%b exp=0f/0110/1110", r, f & 4'b1110, we); end
    endtask

    task automatic test_logic();
        logic [7:0] r; logic [3:0] f, we; int lat;
        run8(OP_AND, 8'hF0, 8'h0F, 3'd0, 4'b0001, r, f, we, lat);
        n_checks++; if ({r, f} !== {8'h00, 4'b1010}) begin n_errors++; $display("FAIL and got=%h/%b exp=00/1010", r, f); end
        n_checks++; if (lat !== 2)       begin n_errors++; $display("FAIL and_lat got=%0d exp=2", lat); end
        run8(OP_XOR, 8'h5A, 8'hFF, 3'd0, 4'b0011, r, f, we, lat);
        n_checks++; if ({r, f} !== {8'hA5, 4'b0000}) begin n_errors++; $display("FAIL xor got=%h/%b exp=a5/0000", r, f); end
        run8(OP_OR, 8'h00, 8'h00, 3'd0, 4'b0111, r, f, we, lat);
        n_checks++; if ({r, f} !== {8'h00, 4'b1000}) begin n_errors++; $display("FAIL or got=%h/%b exp=00/1000", r, f); end
        run8(5'd25, 8'h5A, 8'h33, 3'd0, 4'b1010, r, f, we, lat);
        n_checks++; if ({r, we} !== {8'h5A, 4'b0000}) begin n_errors++; $display("FAIL illegal got=%h/%b exp=5a/0000", r, we); end
        n_checks++; if (lat !== 2)       begin n_errors++; $display("FAIL illegal_lat got=%0d exp=2", lat); end
    endtask

    task automatic test_shifts();
        logic [7:0] r; logic [3:0] f, we; int lat;
        run8(OP_RLC, 8'h85, 8'h00, 3'd0, 4'b0000, r, f, we, lat);
        n_checks++; if ({r, f} !== {8'h0B, 4'b0001}) begin n_errors++; $display("FAIL rlc got=%h/%b exp=0b/0001", r, f); end
        run8(OP_RRC, 8'h01, 8'h00, 3'd0, 4'b0000, r, f, we, lat);
        n_checks++; if ({r, f} !== {8'h80, 4'b0001}) begin n_errors++; $display("FAIL rrc got=%h/%b exp=80/0001", r, f); end
        run8(OP_RL, 8'h80, 8'h00, 3'd0, 4'b0001, r, f, we, lat);
        n_checks++; if ({r, f} !== {8'h01, 4'b0001}) begin n_errors++; $display("FAIL rl got=%h/%b exp=01/0001", r, f); end
        run8(OP_RR, 8'h01, 8'h00, 3'd0, 4'b0000, r, f, we, lat);
        n_checks++; if ({r, f} !== {8'h00, 4'b1001}) begin n_errors++; $display("FAIL rr got=%h/%b exp=00/1001", r, f); end
        run8(OP_SLA, 8'h80, 8'h00, 3'd0, 4'b0000, r, f, we, lat);
        n_checks++; if ({r, f} !== {8'h00, 4'b1001}) begin n_errors++; $display("FAIL sla got=%h/%b exp=00/1001", r, f); end
        run8(OP_SRA, 8'h81, 8'h00, 3'd0, 4'b0000, r, f, we, lat);
        n_checks++; if ({r, f} !== {8'hC0, 4'b0001}) begin n_errors++; $display("FAIL sra got=%h/%b exp=c0/0001", r, f); end
        run8(OP_SWAP, 8'hF1, 8'h00, 3'd0, 4'b0001, r, f, we, lat);
        n_checks++; if ({r, f} !== {8'h1F, 4'b0000}) begin n_errors++; $display("FAIL swap got=%h/%b exp=1f/0000", r, f); end
        run8(OP_SRL, 8'h01, 8'h00, 3'd0, 4'b0000, r, f, we, lat);
        n_checks++; if ({r, f} !== {8'h00, 4'b1001}) begin n_errors++; $display("FAIL srl got=%h/%b exp=00/1001", r, f); end
    endtask

    task automatic test_bitops();
        logic [7:0] r; logic [3:0] f, we; int lat;
        run8(OP_BIT, 8'h7F, 8'h00, 3'd7, 4'b0100, r, f, we, lat);
        n_checks++; if ({f & 4'b1110, we} !== {4'b1010, 4'b1110}) begin n_errors++; $display("FAIL bit7 got=%b/%b exp=1010/1110", f & 4'b1110, we); end
        run8(OP_BIT, 8'h01, 8'h00, 3'd0, 4'b1000, r, f, we, lat);
        n_checks++; if ((f & 4'b1110) !== 4'b0010) begin n_errors++; $display("FAIL bit0 got=%b exp=0010", f & 4'b1110); end
        run8(OP_SET, 8'h7F, 8'h00, 3'd7, 4'b0000, r, f, we, lat);
        n_checks++; if ({r, we} !== {8'hFF, 4'b0000}) begin n_errors++; $display("FAIL set got=%h/%b exp=ff/0000", r, we); end
        run8(OP_RES, 8'hFF, 8'h00, 3'd3, 4'b0000, r, f, we, lat);
        n_checks++; if ({r, we} !== {8'hF7, 4'b0000}) begin n_errors++; $display("FAIL res got=%h/%b exp=f7/0000", r, we); end
    endtask

    task automatic test_daa();
        logic [7:0] r; logic [3:0] f, we; int lat;
        run8(OP_DAA, 8'h3C, 8'h00, 3'd0, 4'b0000, r, f, we, lat);
        n_checks++; if ({r, f & 4'b1011, we} !== {8'h42, 4'b0000, 4'b1011}) begin n_errors++; $display("FAIL daa_add got=%h/%b/%b exp=42/0000/1011", r, f & 4'b1011, we); end
        run8(OP_DAA, 8'h9A, 8'h00, 3'd0, 4'b0000, r, f, we, lat);
        n_checks++; if ({r, f & 4'b1011} !== {8'h00, 4'b1001}) begin n_errors++; $display("FAIL daa_wrap got=%h/%b exp=00/1001", r, f & 4'b1011); end
        run8(OP_DAA, 8'h0F, 8'h00, 3'd0, 4'b0110, r, f, we, lat);
        n_checks++; if ({r, f & 4'b1011} !== {8'h09, 4'b0000}) begin n_errors++; $display("FAIL daa_sub got=%h/%b exp=09/0000", r, f & 4'b1011); end
    endtask

    task automatic test_wide();
        logic [15:0] ra, rb; logic [3:0] fa, fb; int la, lb;
        run16(OP_ADD, 16'hFFFF, 16'h0001, ra, rb, fa, fb, la, lb);
        n_checks++; if ({ra, fa, la[3:0]} !== {16'h0000, 4'b1011, 4'd5}) begin n_errors++; $display("FAIL w16s4_add got=%h/%b/%0d exp=0000/1011/5", ra, fa, la); end
        n_checks++; if ({rb, fb, lb[3:0]} !== {16'h0000, 4'b1011, 4'd2}) begin n_errors++; $display("FAIL w16s16_add got=%h/%b/%0d exp=0000/1011/2", rb, fb, lb); end
        run16(OP_ADD, 16'h0FFF, 16'h0001, ra, rb, fa, fb, la, lb);
        n_checks++; if ({ra, fa} !== {16'h1000, 4'b0010}) begin n_errors++; $display("FAIL w16s4_h got=%h/%b exp=1000/0010", ra, fa); end
        n_checks++; if ({rb, fb} !== {16'h1000, 4'b0010}) begin n_errors++; $display("FAIL w16s16_h got=%h/%b exp=1000/0010", rb, fb); end
        run16(OP_SUB, 16'h1000, 16'h0001, ra, rb, fa, fb, la, lb);
        n_checks++; if ({ra, fa} !== {16'h0FFF, 4'b0110}) begin n_errors++; $display("FAIL w16s4_sub got=%h/%b exp=0fff/0110", ra, fa); end
        n_checks++; if ({rb, fb} !== {16'h0FFF, 4'b0110}) begin n_errors++; $display("FAIL w16s16_sub got=%h/%b exp=0fff/0110", rb, fb); end
        n_checks++; if ({ack_a, ack_b, busy_a, busy_b} !== 4'b1100) begin n_errors++; $display("FAIL w16_idle got=%b exp=1100", {ack_a, ack_b, busy_a, busy_b}); end
    endtask

    task automatic test_back_to_back();
        int n_ack, n_done, n_overlap, n_badres;
        n_ack = 0; n_done = 0; n_overlap = 0; n_badres = 0;
        @(posedge CLK); #1;
        req8 = 1'b1; op8 = OP_ADD; a8 = 8'h01; b8 = 8'h02; fin8 = 4'b0000;
        for (int t = 0; t < 20; t++) begin
            if (ack8) n_ack++;
            if (ack8 && busy8) n_overlap++;
            if (done8) begin
                n_done++;
                if (res8 !== 8'h03) n_badres++;
            end
            @(posedge CLK); #1;
        end
        req8 = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        n_checks++; if (n_ack !== 5)     begin n_errors++; $display("FAIL b2b_accepts got=%0d exp=5", n_ack); end
        n_checks++; if (n_done !== 5)    begin n_errors++; $display("FAIL b2b_dones got=%0d exp=5", n_done); end
        n_checks++; if (n_overlap !== 0) begin n_errors++; $display("FAIL b2b_ack_busy got=%0d exp=0", n_overlap); end
        n_checks++; if (n_badres !== 0)  begin n_errors++; $display("FAIL b2b_res got=%0d bad exp=0", n_badres); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] r; logic [3:0] f, we; int lat, n_done;
        run8(OP_SUB, 8'h10, 8'h01, 3'd0, 4'b0000, r, f, we, lat);
        @(posedge CLK); #1;
        req8 = 1'b1; op8 = OP_ADD; a8 = 8'h11; b8 = 8'h22;
        @(posedge CLK); #1;
        req8 = 1'b0;
        @(posedge CLK); #1;
        nRESET = 1'b0;
        #1;
        n_checks++; if ({res8, flags8, we8} !== 16'h0000) begin n_errors++; $display("FAIL rst_mid_out got=%h/%b/%b exp=00/0000/0000", res8, flags8, we8); end
        n_checks++; if ({ack8, busy8, done8} !== 3'b100) begin n_errors++; $display("FAIL rst_mid_hs got=%b exp=100", {ack8, busy8, done8}); end
        #2;
        nRESET = 1'b1;
        n_done = 0;
        for (int t = 0; t < 6; t++) begin
            if (done8) n_done++;
            @(posedge CLK); #1;
        end
        n_checks++; if (n_done !== 0) begin n_errors++; $display("FAIL rst_mid_done got=%0d exp=0", n_done); end
        n_checks++; if ({ack8, res8} !== {1'b1, 8'h00}) begin n_errors++; $display("FAIL rst_mid_after got=%b/%h exp=1/00", ack8, res8); end
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        test_reset();
        nRESET = 1'b1;
        test_arith();
        test_logic();
        test_shifts();
        test_bitops();
        test_daa();
        test_wide();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/sm83_alu_seq.md
# sm83_alu_seq

Parametrised, multi-cycle successor to the SM83 core ALU. It executes one ALU/CB-prefix operation per request over a `W`-bit datapath. Arithmetic is carried out serially in `S`-bit slices, so one netlist covers both the full-width single-pass case and the nibble-serial case. It computes result and Z/N/H/C flags with a per-flag write mask and signals completion with a req/ack/done handshake. It sits between the register-file operand buses and the flag register, replacing the fixed 8-bit CLA/G-P datapath in wider or area-reduced core variants.

## Interface
Parameters:
- `W`, 8: datapath width. Multiple of 4, ≥ 8.
- `S`, 4: arithmetic slice width. Multiple of 4, divides `W`. `NS = W/S` slices.

Ports:
- `CLK`  in  1: the single clock. All state updates on rising edge.
- `nRESET`  in  1: asynchronous, active-low reset.
- `req`  in  1: operation request.
- `op`  in  5: opcode (see Operation).
- `bitsel`  in  clog2(W): bit index for BIT/RES/SET.
- `a`  in  W: operand 1 (accumulator / CB target).
- `b`  in  W: operand 2.
- `flags_in`  in  4: current {Z,N,H,C}, used by ADC/SBC/RL/RR/DAA.
- `ack`  out  1: high in IDLE. A request is accepted when `req & ack`.
- `busy`  out  1: high in EXEC and DONE.
- `done`  out  1: one-cycle pulse; `res`/`flags`/`flags_we` are valid this cycle.
- `res`  out  W: result register.
- `flags`  out  4: {Z,N,H,C}.
- `flags_we`  out  4: per-flag update mask, same order as `flags`.

## Operation
Opcodes:
- 0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 XOR, 6 OR, 7 CP, 8 RLC, 9 RRC, 10 RL, 11 RR, 12 SLA, 13 SRA, 14 SWAP, 15 SRL, 16 BIT, 17 RES, 18 SET, 19 DAA, 20 INC, 21 DEC.
- 22–31 are illegal: `res=a`, `flags_we=0000`, completes normally.

Operand capture and state:
- `a`, `b`, `op`, `bitsel` and `flags_in` are captured on acceptance.
- Later changes on these inputs have no effect on the operation in progress.
- FSM: IDLE → (req&ack) → EXEC → DONE → IDLE.

EXEC behaviour:
- Serial ops: ADD, ADC, SUB, SBC, CP, INC, DEC.
  - Take `NS` EXEC cycles. Slice k (LSB first) is computed in EXEC cycle k.
  - Inter-slice carry/borrow is held in a register. Initial carry is C for ADC/SBC, 1 for INC/DEC, else 0.
- All other ops take exactly one EXEC cycle.

Flag rules:
- Z: result == 0. For CP, the difference is compared and `res=a`. For BIT, Z = ~a[bitsel].
- H: carry/borrow out of bit 3. C: carry/borrow out of bit W-1.
- Shifts: C = bit shifted out, N=H=0.
- SWAP: exchange the upper and lower W/2 halves; C=0.
- AND sets H=1. XOR and OR set H=0. All three clear N and C.
- INC/DEC: `flags_we=1110` (C unchanged).
- BIT: N=0, H=1, `flags_we=1110`.
- RES/SET: `flags_we=0000`.
- DAA: SM83 rules on the low byte, upper W-8 bits pass through. N is unchanged (`flags_we=1011`), H=0.

Slice-width invariance:
- Results and flags are bit-identical for every legal `S`.

## Timing
- Request accepted in cycle T:
  - Serial op: `done` in cycle T+NS+1.
  - Other ops: `done` in cycle T+2.
- `res`, `flags` and `flags_we` load on the EXEC→DONE edge. They hold until the next DONE load.
- `ack=0` throughout EXEC and DONE; `req` is ignored there.
- `ack` returns in the cycle after `done`. Minimum spacing between acceptances is latency+1.
- Reset (asynchronous, any state, including mid-EXEC):
  - State goes to IDLE and the slice counter and carry register clear.
  - `res=0`, `flags=0000`, `flags_we=0000`, `done=0`, `busy=0`, `ack=1` once `nRESET` releases.
  - A partially computed result is discarded.
- The slice counter wraps at `NS-1`. No EXEC cycle beyond `NS` exists.

## Structure
- Package `sm83_alu_pkg`:
  - opcode enum `alu_op_t`
  - FSM enum `alu_state_t`
  - flag index constants `FLAG_Z=3`, `FLAG_N=2`, `FLAG_H=1`, `FLAG_C=0`
- Sub-module `alu_slice`: S-bit add/subtract with carry-in, carry-out and bit-3 carry. Instantiated once and reused across slices.
- Elaboration check: `W%4==0`, `W>=8`, `S%4==0`, `W%S==0`.

## Test plan
- W=8, S=4: ADD a=0x3A b=0xC6 -> `res=0x00`, flags 1011 (Z H C), `flags_we=1111`, `done` at T+3.
- SUB a=0x10 b=0x01 -> `res=0x0F`, flags 0110; CP with the same operands -> `res=0x10`, flags 0110.
- DAA a=0x3C, `flags_in=0000` -> `res=0x42`, Z=0 H=0 C=0, `flags_we=1011`.
- BIT bitsel=7 a=0x7F -> Z=1 N=0 H=1, `flags_we=1110`; SET bitsel=7 -> `res=0xFF`, `flags_we=0000`.
- W=16, S=4: ADD 0xFFFF+0x0001 -> `res=0x0000`, flags 1011, `done` at T+5. Repeat with S=16 -> identical result, `done` at T+2.
- Protocol and reset:
  - `req` held high through a serial op -> exactly one acceptance per IDLE cycle.
  - `nRESET` pulsed in the second EXEC cycle -> no `done`, all outputs zero, `ack=1` after release.
